axis_byte_packer: RTL and testbench
===================================

# axis_byte_packer

Generalised AXI-Stream byte packer. It removes null bytes at any lane position (any `tkeep` pattern, including all-zero beats) and repacks the survivors into contiguous, LSB-aligned output beats. All output beats are full except the final beat of each packet. It tolerates gaps in `s_axis_tvalid`, applies full backpressure, and reports the byte length of each packet. It sits between framing logic that produces sparse or misaligned streams and downstream consumers that require dense beats.

## Interface
- `AXIS_DW`, 64: data width in bits; multiple of 8, at least 16.
- `AXIS_KW`, `AXIS_DW/8`: keep width; derived, do not override.
- `LEN_W`, 16: width of the packet byte-count output.
- `clk` in 1: clock; all logic is on the rising edge.
- `rst_n` in 1: reset; asynchronous, active-low.
- `s_axis_tvalid` in 1: input beat valid; may deassert mid-packet.
- `s_axis_tready` out 1: input ready.
- `s_axis_tdata` in `AXIS_DW`: input data; lane *i* = bits [8i+7:8i].
- `s_axis_tkeep` in `AXIS_KW`: input byte enables; any pattern is legal.
- `s_axis_tlast` in 1: last beat of the packet.
- `m_axis_tvalid` out 1: output valid.
- `m_axis_tready` in 1: output ready.
- `m_axis_tdata` out `AXIS_DW`: packed data.
- `m_axis_tkeep` out `AXIS_KW`: either all ones, or (on a tlast beat) contiguous from lane 0; may be all zero on a tlast beat.
- `m_axis_tlast` out 1: last beat of the packet.
- `m_pkt_bytes` out `LEN_W`: total kept bytes of the packet; valid while `m_axis_tvalid && m_axis_tlast`; saturates at all-ones.

## Operation
- **Buffer.** 2·`AXIS_KW` byte slots plus a byte count `cnt` (0..2·`AXIS_KW`).
  - Slot 0 is the LSB byte.
  - `m_axis_tdata` = slots [0..KW-1].
  - Slots at index ≥ `cnt` always hold 0x00.
- **Input accept.** An input beat is accepted when `s_axis_tvalid && s_axis_tready`.
  - Its kept lanes are compacted in ascending lane order.
  - They are written starting at slot `cnt'`, where `cnt'` = `cnt` − `AXIS_KW` if an output beat pops in the same cycle, else `cnt`.
  - Then `cnt` ← `cnt'` + popcount(`tkeep`).
- **Output pop.** On `m_axis_tvalid && m_axis_tready`:
  - the buffer shifts down by `AXIS_KW` slots (or clears, on the final beat);
  - vacated slots are zeroed;
  - `cnt` decrements accordingly.
- **flush flag.**
  - Set when a tlast input beat is accepted.
  - Cleared when the output tlast beat pops.
  - While `flush` = 1, `s_axis_tready` = 0.
- **`s_axis_tready`** = `rst_n && !flush && (cnt < AXIS_KW || (m_axis_tvalid && m_axis_tready && !m_axis_tlast))`.
  - This is a combinational path from `m_axis_tready`.
  - It guarantees `cnt` ≤ 2·`AXIS_KW` − 1 after any accept.
- **`m_axis_tvalid`** = `cnt >= AXIS_KW || flush`.
- **`m_axis_tlast`** = `flush && cnt <= AXIS_KW`.
- **`m_axis_tkeep`**:
  - all ones when `cnt >= AXIS_KW`;
  - otherwise (2^`cnt`) − 1.
  - Data lanes not covered by keep are 0x00.
- **Null-only packet.** If the packet's beats (tlast beat included) carry zero bytes in total, the output is exactly one beat: `tkeep` = 0, `tlast` = 1, `m_pkt_bytes` = 0. Packet boundaries are never dropped.
- **Zero-keep beat without tlast.** The beat is accepted and consumed; no output is produced.
- **Length counter.**
  - Accumulates popcount(`tkeep`) of each accepted input beat.
  - Is copied to the `m_pkt_bytes` register when the tlast input beat is accepted.
  - Is cleared for the next packet when that tlast beat is accepted.
  - Saturates rather than wraps.

## Timing
- **Reset (`rst_n` low):**
  - `cnt` = 0, `flush` = 0, buffer all 0x00, length counter 0, `m_pkt_bytes` = 0;
  - `m_axis_tvalid` = 0, `m_axis_tdata` = 0, `m_axis_tkeep` = 0, `m_axis_tlast` = 0;
  - `s_axis_tready` = 0.
- **Reset mid-packet:** buffered bytes are discarded with no output. The first beat after release starts a new packet.
- **Latency:** a full input beat accepted at edge N (with `cnt` = 0) is presented on `m_axis` after edge N and can pop at edge N+1.
- **Throughput:** 1 beat/cycle sustained with dense input and `m_axis_tready` = 1.
- **Flush bubble:** each tlast costs up to 2 output cycles, during which input is stalled.
- **Output hold:** while `m_axis_tvalid && !m_axis_tready`, all `m_axis_*` and `m_pkt_bytes` hold stable.
- **Back-to-back:** `s_axis_tready` rises in the cycle after the output tlast beat pops.

## Test plan
- **Dense packet.** `AXIS_DW`=32; 3 beats with keep 4'hF, data 0x04030201, 0x08070605, 0x0C0B0A09, tlast on beat 3.
  - Expect 3 identical output beats, one cycle later.
  - tlast on beat 3; `m_pkt_bytes` = 12.
- **Sparse packet.** Beat 1: keep 4'b0101, data 0x44332211. Beat 2: keep 4'b1010, data 0x88776655, tlast.
  - Expect one beat: data 0x88663311, keep 4'hF, tlast; `m_pkt_bytes` = 4.
- **Leading/trailing nulls.** Beat 1: keep 4'b1100, data 0xDDCC0000. Beat 2: keep 4'hF, data 0x44332211. Beat 3: keep 4'b0011, data 0x00006655, tlast.
  - Expect beat 0x2211DDCC, keep F, tlast=0.
  - Then beat 0x66554433, keep F, tlast=1; `m_pkt_bytes` = 8.
- **Null-only packet.** Beat 1: keep 4'h0, no tlast. Beat 2: keep 4'h0, tlast.
  - Expect one beat: keep 4'h0, data 0, tlast; `m_pkt_bytes` = 0.
- **Backpressure and gaps.** Random `s_axis_tvalid` gaps plus `m_axis_tready` held low for 5 cycles with `cnt` ≥ 4.
  - Expect `s_axis_tready` = 0 and outputs stable throughout the stall.
  - Expect no byte loss or duplication against the scoreboard over 1000 random packets.
- **Reset mid-packet.** Drop `rst_n` asynchronously after 2 beats of a 5-beat packet.
  - Expect outputs at reset values immediately.
  - Expect the next packet to be output correctly, with no residue from the aborted packet.

Source files
------------

// File: rtl/axis_byte_packer.sv
// rtl/axis_byte_packer.sv - AXI-Stream null-byte remover and LSB-aligned repacker
module axis_byte_packer #(
    parameter int AXIS_DW = 64,
    parameter int AXIS_KW = AXIS_DW / 8,
    parameter int LEN_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               s_axis_tvalid,
    output logic               s_axis_tready,
    input  logic [AXIS_DW-1:0] s_axis_tdata,
    input  logic [AXIS_KW-1:0] s_axis_tkeep,
    input  logic               s_axis_tlast,
    output logic               m_axis_tvalid,
    input  logic               m_axis_tready,
    output logic [AXIS_DW-1:0] m_axis_tdata,
    output logic [AXIS_KW-1:0] m_axis_tkeep,
    output logic               m_axis_tlast,
    output logic [LEN_W-1:0]   m_pkt_bytes
);
    localparam int SLOTS = 2 * AXIS_KW;
    localparam int CW    = $clog2(SLOTS + 1);
    localparam int BW    = SLOTS * 8;

    logic [BW-1:0]      buf_q, buf_d, base;
    logic [CW-1:0]      cnt_q, cnt_d, base_cnt, pc;
    logic [CW-1:0]      pre [AXIS_KW+1];
    logic [AXIS_DW-1:0] comp;
    logic               flush_q, flush_d;
    logic [LEN_W-1:0]   len_q, len_d, pkt_q, pkt_d, len_sat;
    logic [LEN_W:0]     len_sum;
    logic [AXIS_KW-1:0] part_keep;
    logic               pop, accept;

    assign m_axis_tvalid = (cnt_q >= CW'(AXIS_KW)) || flush_q;
    assign m_axis_tlast  = flush_q && (cnt_q <= CW'(AXIS_KW));
    assign pop           = m_axis_tvalid && m_axis_tready;
    assign s_axis_tready = rst_n && !flush_q &&
                           ((cnt_q < CW'(AXIS_KW)) || (pop && !m_axis_tlast));
    assign accept        = s_axis_tvalid && s_axis_tready;

    // Lane i lands at compacted position pre[i] = number of kept lanes below it.
    always_comb begin
        pre[0] = '0;
        for (int i = 0; i < AXIS_KW; i++) begin
            pre[i+1] = pre[i] + {{(CW-1){1'b0}}, s_axis_tkeep[i]};
        end
        comp = '0;
        for (int k = 0; k < AXIS_KW; k++) begin
            for (int i = 0; i < AXIS_KW; i++) begin
                if (s_axis_tkeep[i] && (pre[i] == CW'(k))) begin
                    comp[k*8 +: 8] = s_axis_tdata[i*8 +: 8];
                end
            end
        end
    end

    assign pc = pre[AXIS_KW];

    always_comb begin
        base     = buf_q;
        base_cnt = cnt_q;
        if (pop) begin
            if (m_axis_tlast) begin
                base     = '0;
                base_cnt = '0;
            end else begin
                base     = buf_q >> (AXIS_KW * 8);
                base_cnt = cnt_q - CW'(AXIS_KW);
            end
        end
        buf_d = base;
        cnt_d = base_cnt;
        if (accept) begin
            for (int j = 0; j < SLOTS; j++) begin
                for (int k = 0; k < AXIS_KW; k++) begin
                    if ((CW'(k) < pc) && ((base_cnt + CW'(k)) == CW'(j))) begin
                        buf_d[j*8 +: 8] = comp[k*8 +: 8];
                    end
                end
            end
            cnt_d = base_cnt + pc;
        end
    end

    always_comb begin
        len_sum = {1'b0, len_q} + (LEN_W+1)'(pc);
        len_sat = len_sum[LEN_W] ? {LEN_W{1'b1}} : len_sum[LEN_W-1:0];
        len_d   = len_q;
        pkt_d   = pkt_q;
        flush_d = flush_q;
        if (pop && m_axis_tlast) begin
            flush_d = 1'b0;
        end
        if (accept) begin
            if (s_axis_tlast) begin
                pkt_d   = len_sat;
                len_d   = '0;
                flush_d = 1'b1;
            end else begin
                len_d   = len_sat;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_q   <= '0;
            cnt_q   <= '0;
            flush_q <= 1'b0;
            len_q   <= '0;
            pkt_q   <= '0;
        end else begin
            buf_q   <= buf_d;
            cnt_q   <= cnt_d;
            flush_q <= flush_d;
            len_q   <= len_d;
            pkt_q   <= pkt_d;
        end
    end

    always_comb begin
        part_keep = '0;
        for (int i = 0; i < AXIS_KW; i++) begin
            part_keep[i] = CW'(i) < cnt_q;
        end
    end

    assign m_axis_tkeep = (cnt_q >= CW'(AXIS_KW)) ? {AXIS_KW{1'b1}} : part_keep;
    assign m_axis_tdata = buf_q[AXIS_DW-1:0];
    assign m_pkt_bytes  = pkt_q;
endmodule

// File: tb/tb_axis_byte_packer.sv
// tb/tb_axis_byte_packer.sv - self-checking bench for axis_byte_packer
module tb_axis_byte_packer;
    localparam int DW = 32;
    localparam int KW = 4;
    localparam int LW = 8;

    logic          clk, rst_n;
    logic          s_axis_tvalid, s_axis_tready, s_axis_tlast;
    logic [DW-1:0] s_axis_tdata;
    logic [KW-1:0] s_axis_tkeep;
    logic          m_axis_tvalid, m_axis_tready, m_axis_tlast;
    logic [DW-1:0] m_axis_tdata;
    logic [KW-1:0] m_axis_tkeep;
    logic [LW-1:0] m_pkt_bytes;

    logic fixed_rdy, rnd_rdy, rand_rdy, exact_mode;
    assign m_axis_tready = rand_rdy ? rnd_rdy : fixed_rdy;

    axis_byte_packer #(.AXIS_DW(DW), .LEN_W(LW)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tlast(s_axis_tlast),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast),
        .m_pkt_bytes(m_pkt_bytes)
    );

    typedef struct {
        logic [31:0] d;  logic [3:0] k;  logic l;
        logic has_out;
        logic [31:0] od; logic [3:0] ok; logic ol; int ob;
    } vec_t;
    typedef struct { logic [31:0] d; logic [3:0] k; logic l; int b; } out_t;

    vec_t vecs[10];
    out_t exp_q[$];
    logic [7:0] exp_bytes[$];
    int exp_lens[$];
    int n_checks = 0;
    int n_fail = 0;
    int act_len = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        rnd_rdy = 1'b1;
        forever begin
            @(posedge clk); #1;
            rnd_rdy = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int sat(input int n);
        return (n > 255) ? 255 : n;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
        int  waited = 0;
        bit  done = 0;
        s_axis_tvalid = 1'b1; s_axis_tdata = d; s_axis_tkeep = k; s_axis_tlast = l;
        while (!done) begin
            @(negedge clk);
            if (s_axis_tready) begin
                done = 1;
            end else if (waited++ > 300) begin
                n_checks++; n_fail++;
                $display("FAIL accept_timeout: beat %0h not accepted, expected acceptance", d);
                done = 1;
            end
            @(posedge clk); #1;
        end
        s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tlast = 1'b0;
    endtask

    task automatic drain();
        int w = 0;
        while ((exp_q.size() != 0 || exp_bytes.size() != 0 || exp_lens.size() != 0) && w < 3000) begin
            @(posedge clk); #1;
            w++;
        end
        if (w >= 3000) begin
            n_checks++; n_fail++;
            $display("FAIL drain: %0d beats %0d bytes %0d packets outstanding, expected none",
                     exp_q.size(), exp_bytes.size(), exp_lens.size());
        end
    endtask

    // Output monitor: exact beat compare for directed tests, byte scoreboard otherwise.
    always @(negedge clk) begin
        out_t e;
        logic [3:0] kp1;
        if (rst_n && m_axis_tvalid && m_axis_tready) begin
            if (exact_mode) begin
                if (exp_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected_beat: got %0h, expected no beat", m_axis_tdata);
                end else begin
                    e = exp_q.pop_front();
                    check("beat_data", m_axis_tdata, e.d);
                    check("beat_keep", m_axis_tkeep, e.k);
                    check("beat_last", m_axis_tlast, e.l);
                    if (e.l) check("beat_pkt_bytes", m_pkt_bytes, e.b);
                end
            end else begin
                for (int k = 0; k < KW; k++) begin
                    if (m_axis_tkeep[k]) begin
                        act_len++;
                        if (exp_bytes.size() == 0) begin
                            n_checks++; n_fail++;
                            $display("FAIL byte_overrun: got byte %0h, expected none", m_axis_tdata[k*8 +: 8]);
                        end else begin
                            check("pkt_byte", m_axis_tdata[k*8 +: 8], exp_bytes.pop_front());
                        end
                    end else begin
                        check("pad_zero", m_axis_tdata[k*8 +: 8], 0);
                    end
                end
                if (!m_axis_tlast) begin
                    check("full_keep", m_axis_tkeep, 4'hF);
                end else begin
                    kp1 = m_axis_tkeep + 4'd1;
                    check("last_keep_contig", m_axis_tkeep & kp1, 0);
                    if (exp_lens.size() == 0) begin
                        n_checks++; n_fail++;
                        $display("FAIL unexpected_tlast: got tlast, expected no packet end");
                    end else begin
                        check("pkt_len", act_len, exp_lens[0]);
                        check("pkt_bytes", m_pkt_bytes, sat(exp_lens[0]));
                        void'(exp_lens.pop_front());
                    end
                    act_len = 0;
                end
            end
        end
    end

    initial begin
        int nb, len;
        bit nullpkt;
        logic [31:0] d;
        logic [3:0]  k;

        vecs[0] = '{32'h04030201, 4'hF, 1'b0, 1'b1, 32'h04030201, 4'hF, 1'b0, 0};
        vecs[1] = '{32'h08070605, 4'hF, 1'b0, 1'b1, 32'h08070605, 4'hF, 1'b0, 0};
        vecs[2] = '{32'h0C0B0A09, 4'hF, 1'b1, 1'b1, 32'h0C0B0A09, 4'hF, 1'b1, 12};
        vecs[3] = '{32'h44332211, 4'h5, 1'b0, 1'b0, 32'h0, 4'h0, 1'b0, 0};
        vecs[4] = '{32'h88776655, 4'hA, 1'b1, 1'b1, 32'h88663311, 4'hF, 1'b1, 4};
        vecs[5] = '{32'hDDCC0000, 4'hC, 1'b0, 1'b0, 32'h0, 4'h0, 1'b0, 0};
        vecs[6] = '{32'h44332211, 4'hF, 1'b0, 1'b1, 32'h2211DDCC, 4'hF, 1'b0, 0};
        vecs[7] = '{32'h00006655, 4'h3, 1'b1, 1'b1, 32'h66554433, 4'hF, 1'b1, 8};
        vecs[8] = '{32'h00000000, 4'h0, 1'b0, 1'b0, 32'h0, 4'h0, 1'b0, 0};
        vecs[9] = '{32'h00000000, 4'h0, 1'b1, 1'b1, 32'h0, 4'h0, 1'b1, 0};

        rst_n = 1'b0; fixed_rdy = 1'b1; rand_rdy = 1'b0; exact_mode = 1'b1;
        s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tlast = 1'b0;
        #12;
        check("rst_tvalid", m_axis_tvalid, 0);
        check("rst_tdata", m_axis_tdata, 0);
        check("rst_tkeep", m_axis_tkeep, 0);
        check("rst_tlast", m_axis_tlast, 0);
        check("rst_s_tready", s_axis_tready, 0);
        check("rst_pkt_bytes", m_pkt_bytes, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            drive_beat(vecs[i].d, vecs[i].k, vecs[i].l);
            if (vecs[i].has_out) exp_q.push_back('{vecs[i].od, vecs[i].ok, vecs[i].ol, vecs[i].ob});
            if (i == 0) begin
                @(negedge clk);
                check("latency_tvalid", m_axis_tvalid, 1);
                check("throughput_s_tready", s_axis_tready, 1);
                @(posedge clk); #1;
            end
        end
        drain();

        // Backpressure: output held with cnt = 4, input must stall.
        fixed_rdy = 1'b0;
        drive_beat(32'hA4A3A2A1, 4'hF, 1'b0);
        exp_q.push_back('{32'hA4A3A2A1, 4'hF, 1'b0, 0});
        s_axis_tvalid = 1'b1; s_axis_tdata = 32'hB4B3B2B1; s_axis_tkeep = 4'hF; s_axis_tlast = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("stall_s_tready", s_axis_tready, 0);
            check("stall_tvalid", m_axis_tvalid, 1);
            check("stall_tdata", m_axis_tdata, 32'hA4A3A2A1);
            check("stall_tkeep", m_axis_tkeep, 4'hF);
            check("stall_tlast", m_axis_tlast, 0);
        end
        @(posedge clk); #1;
        fixed_rdy = 1'b1;
        drive_beat(32'hB4B3B2B1, 4'hF, 1'b1);
        exp_q.push_back('{32'hB4B3B2B1, 4'hF, 1'b1, 8});
        drain();

        // Reset mid-packet: buffered bytes vanish, next packet is clean.
        fixed_rdy = 1'b0;
        drive_beat(32'h0000BBAA, 4'h3, 1'b0);
        drive_beat(32'h0000DDCC, 4'h3, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_tvalid", m_axis_tvalid, 0);
        check("mid_rst_tdata", m_axis_tdata, 0);
        check("mid_rst_tkeep", m_axis_tkeep, 0);
        check("mid_rst_tlast", m_axis_tlast, 0);
        check("mid_rst_s_tready", s_axis_tready, 0);
        check("mid_rst_pkt_bytes", m_pkt_bytes, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        fixed_rdy = 1'b1;
        drive_beat(32'h00332211, 4'h7, 1'b1);
        exp_q.push_back('{32'h00332211, 4'h7, 1'b1, 3});
        drain();

        // Random phase: gaps, random backpressure, byte-level scoreboard.
        exact_mode = 1'b0;
        rand_rdy = 1'b1;
        for (int b = 0; b < 70; b++) begin
            d = $urandom;
            for (int j = 0; j < KW; j++) exp_bytes.push_back(d[j*8 +: 8]);
            if (b == 69) exp_lens.push_back(280);
            drive_beat(d, 4'hF, b == 69);
        end
        for (int p = 0; p < 1000; p++) begin
            nb = $urandom_range(1, 6);
            nullpkt = ($urandom_range(0, 19) == 0);
            len = 0;
            for (int b = 0; b < nb; b++) begin
                k = nullpkt ? 4'h0 : 4'($urandom_range(0, 15));
                d = $urandom;
                for (int j = 0; j < KW; j++) begin
                    if (k[j]) begin
                        exp_bytes.push_back(d[j*8 +: 8]);
                        len++;
                    end
                end
                if (b == nb - 1) exp_lens.push_back(len);
                if ($urandom_range(0, 3) == 0) begin
                    repeat ($urandom_range(1, 3)) begin
                        @(posedge clk); #1;
                    end
                end
                drive_beat(d, k, b == nb - 1);
            end
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
